// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl (with sub-module lookahead_add)
// Purpose  : Adds two WIDTH-bit operands one nibble per clock through one
//            shared 4-bit carry-lookahead slice. The LSB nibble goes first.
//            A carry register holds the carry between nibbles.
//            Optional subtract mode is built when macro NSA_SUB_EN is defined.
// Params   : WIDTH - operand/result width (multiple of 4, >= 8)
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - request, accepted only while ready=1
//            A, B, Cin       - operands and carry-in, sampled on accept
//            sub             - subtract select (NSA_SUB_EN builds only)
//            ready/busy/done - IDLE / RUN / one-cycle DONE indicators
//            Sum, Cout       - result register and final carry-out
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// lookahead_add : 4-bit carry-lookahead adder slice, purely combinational.
// ----------------------------------------------------------------------------
module lookahead_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    // Each carry is flattened from generate/propagate terms, so no carry
    // ripples through an earlier carry signal.
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl : IDLE -> RUN (NIB cycles) -> DONE sequencer.
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NSA_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] res_shifted;

  // Subtraction is A + ~B + 1: invert every B nibble on its way into the
  // slice and seed the carry register with 1 at accept time.
`ifdef NSA_SUB_EN
  assign slice_b = b_q[3:0] ^ {4{sub_q}};
`else
  assign slice_b = b_q[3:0];
`endif

  lookahead_add u_slice (
    .a    (a_q[3:0]),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The newest slice nibble enters at the top. After NIB shifts the first
  // (LSB) nibble has reached bit 0, so the register holds the whole result.
  assign res_shifted = {slice_sum, res_q[WIDTH-1:4]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef NSA_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
`ifdef NSA_SUB_EN
          sub_d   = sub;
          if (sub) begin
            carry_d = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        res_d   = res_shifted;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_NIB) begin
          // Only this edge updates the visible result. Sum/Cout keep the
          // previous answer while a new operation is in progress.
          sum_d   = res_shifted;
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The status outputs are registered from the next state, so each one
    // lines up exactly with the state it reports.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NSA_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NSA_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Directed self-checking bench for nibble_serial_adder_ctrl at
//            WIDTH=16. The expected values are hand-computed constants.
//            Subtract vectors are included when NSA_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             sub_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Cin   (cin_in),
`ifdef NSA_SUB_EN
    .sub   (sub_in),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .Sum   (sum_out),
    .Cout  (cout_out)
  );

  // One rising edge, then move to the falling edge to sample and drive.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept on the next edge, then check the whole timeline of one operation:
  // busy through RUN, done exactly after the 4th RUN edge, ready one edge later.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic sb,
                        input logic [15:0] exp_sum, input logic exp_cout);
    a_in = a; b_in = b; cin_in = cin; sub_in = sb; start = 1'b1;
    step();                                   // edge 0: accept
    start = 1'b0;
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    chk({tag, ".ready0"}, 32'(ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();                                 // edges 1..3
      chk({tag, ".nodone"}, 32'(done), 32'd0);
    end
    step();                                   // edge 4
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".sum"}, 32'(sum_out), 32'(exp_sum));
    chk({tag, ".cout"}, 32'(cout_out), 32'(exp_cout));
    step();                                   // edge 5
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".sum_hold"}, 32'(sum_out), 32'(exp_sum));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; a_in = 16'h1111; b_in = 16'h2222;
    cin_in = 1'b0; sub_in = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", 32'(sum_out), 32'h0);
    chk("rst.cout", 32'(cout_out), 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst.idle", 32'(ready), 32'd1);

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("msb", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Start while busy: the extra requests on edges 1..3 must be dropped.
    a_in = 16'h0001; b_in = 16'h0001; cin_in = 1'b0; start = 1'b1;
    step();                                   // edge 0
    a_in = 16'hAAAA; b_in = 16'h5555;
    step(); step(); step();                   // edges 1..3, start held
    chk("busy.sum_old", 32'(sum_out), 32'hFFFF);
    start = 1'b0;
    step();                                   // edge 4
    chk("busy.done", 32'(done), 32'd1);
    chk("busy.sum", 32'(sum_out), 32'h0002);
    chk("busy.cout", 32'(cout_out), 32'd0);
    step();                                   // edge 5
    chk("busy.ready", 32'(ready), 32'd1);
    step();
    chk("busy.noexec", 32'(busy), 32'd0);
    chk("busy.nodone", 32'(done), 32'd0);
    chk("busy.sum2", 32'(sum_out), 32'h0002);

    // Reset in the middle of RUN aborts the operation.
    a_in = 16'h00FF; b_in = 16'h0001; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    step();                                   // edge 1
    rst = 1'b1;
    step();                                   // edge 2 with reset
    chk("abort.ready", 32'(ready), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.sum", 32'(sum_out), 32'h0);
    chk("abort.cout", 32'(cout_out), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort.nodone", 32'(done), 32'd0);
    end
    run_op("after", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0);

`ifdef NSA_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub0add", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a WIDTH-bit addition using a single 4-bit carry-lookahead slice (`lookahead_add`), one nibble per clock, LSB nibble first, with the carry held in a register between nibbles. It trades latency for area: wide adds run through one shared 4-bit lookahead adder. It sits between a requester issuing start/operand transactions and the `lookahead_add` instance it owns.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8. NIB = WIDTH/4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only on an edge where ready=1
- A  in  WIDTH  operand A, sampled on accept edge
- B  in  WIDTH  operand B, sampled on accept edge
- Cin  in  1  carry-in, sampled on accept edge
- sub  in  1  subtract select, sampled on accept edge (present only with NSA_SUB_EN)
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, high in DONE
- Sum  out  WIDTH  result register
- Cout  out  1  carry-out of the MSB nibble

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: ready=1, busy=0, done=0, Sum=0, Cout=0, internal operand/result shift registers 0, carry register 0, nibble counter 0.
- IDLE: if start=1 at the edge, latch A, B into operand shift registers, load Cin into the carry register, clear counter, go to RUN. Otherwise stay.
- RUN: the slice receives the low nibble of each operand register plus the carry register. Each edge:
  - Slice Sum is shifted into the top of the result register; both operand registers shift right by 4.
  - Carry register ← slice Cout; counter increments.
  - When counter = NIB−1 at the edge: Sum ← completed result, Cout ← slice Cout, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE is ignored; it is neither queued nor remembered.
- Sum/Cout change only on the RUN→DONE edge and on reset; they hold the last result through IDLE and the partial progress of the next operation.
- Arithmetic: Sum = (A + B + Cin) mod 2^WIDTH, Cout = bit WIDTH of that sum. Carry propagates between nibbles only through the carry register; no combinational path from the slice to any output.
- Reset at any state, including mid-RUN, aborts the operation: no done pulse, outputs return to reset values, next cycle is IDLE.

## Timing
- Accept edge = edge k where ready=1 and start=1.
- RUN occupies edges k+1 … k+NIB; done high during the cycle after edge k+NIB; Sum/Cout valid from that cycle.
- Throughput: one operation per NIB+2 cycles when start is held high (IDLE, NIB×RUN, DONE).
- WIDTH=16: accept on edge 0, done high after edge 4, ready high again after edge 5.
- rst has priority over start at the same edge.

## Configuration
- NSA_SUB_EN defined: port sub exists. With sub=1 latched, each B nibble into the slice is inverted and the carry register is loaded with 1 (Cin ignored); Sum = (A − B) mod 2^WIDTH, Cout = 1 means no borrow (A ≥ B unsigned). sub=0 behaves as addition.
- NSA_SUB_EN undefined: no sub port, no inversion logic; add only.

## Test plan
- Reset: hold rst 2 cycles with start=1 → ready=1, busy=0, done=0, Sum=0x0000, Cout=0, no operation accepted.
- Add (WIDTH=16): A=0x1234, B=0x4321, Cin=0, start accepted edge 0 → done high after edge 4, Sum=0x5555, Cout=0; ready back after edge 5.
- Full ripple: A=0xFFFF, B=0x0000, Cin=1 → Sum=0x0000, Cout=1; A=0x8000, B=0x8000, Cin=0 → Sum=0x0000, Cout=1.
- Start while busy: accept A=0x0001, B=0x0001; on edges 1–3 pulse start with A=0xAAAA, B=0x5555 → single done, Sum=0x0002; second request not executed.
- Reset mid-RUN: accept A=0x00FF, B=0x0001, assert rst at edge 2 → no done pulse, Sum=0, ready=1 next cycle; following op A=0x0F0F, B=0x0101 → Sum=0x1010, Cout=0.
- NSA_SUB_EN: A=0x0005, B=0x0007, sub=1 → Sum=0xFFFE, Cout=0; A=0x0007, B=0x0005, sub=1 → Sum=0x0002, Cout=1.
